// File: rtl/sdram_slot_arb_pkg.sv
// sdram_arb_pkg: shared types for the SDRAM slot arbiter.
//   owner_e : debug encoding of who drives the current slot
//   src_e   : source tag of a buffered background request
//   bg_t    : background request register {valid, src, we, addr, data}
//   ADDR_W_DEF : default SDRAM byte-address width
package sdram_arb_pkg;
  localparam int ADDR_W_DEF = 25;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LDR  = 2'd2,
    OWN_AUX  = 2'd3
  } owner_e;

  typedef enum logic {
    SRC_LDR = 1'b0,
    SRC_AUX = 1'b1
  } src_e;

  // addr is sized for the default (widest supported) bus; narrower
  // instances zero-extend into it.
  typedef struct packed {
    logic                  valid;
    src_e                  src;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [7:0]            data;
  } bg_t;
endpackage

// File: rtl/sdram_slot_arb_if.sv
// sdram_slot_arb_if: all non-clock signals of the slot arbiter.
//   slave  : arbiter side (core/loader/aux/sdram_do in; sdram_*, status out)
//   master : environment side (mirror of slave)
interface sdram_slot_arb_if #(
  parameter int ADDR_W = sdram_arb_pkg::ADDR_W_DEF
);
  import sdram_arb_pkg::*;

  logic              mem_sync;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [7:0]        core_din;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_data;
  logic              ldr_full;
  logic              ldr_overflow;
  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [7:0]        aux_din;
  logic              aux_ack;
  logic [7:0]        aux_rdata;
  logic              aux_rvalid;
  logic [ADDR_W-1:0] sdram_adr;
  logic              sdram_we;
  logic [7:0]        sdram_di;
  logic [7:0]        sdram_do;
  owner_e            owner;

  modport slave (
    input  mem_sync, core_req, core_we, core_addr, core_din,
           ldr_we, ldr_addr, ldr_data,
           aux_req, aux_we, aux_addr, aux_din, sdram_do,
    output ldr_full, ldr_overflow, aux_ack, aux_rdata, aux_rvalid,
           sdram_adr, sdram_we, sdram_di, owner
  );

  modport master (
    output mem_sync, core_req, core_we, core_addr, core_din,
           ldr_we, ldr_addr, ldr_data,
           aux_req, aux_we, aux_addr, aux_din, sdram_do,
    input  ldr_full, ldr_overflow, aux_ack, aux_rdata, aux_rvalid,
           sdram_adr, sdram_we, sdram_di, owner
  );
endinterface

// File: rtl/sdram_slot_arb_fifo.sv
// sdram_arb_fifo: synchronous FIFO for loader write strobes.
//   clk, rst        : clock, async active-high reset
//   i_push / i_din  : write; ignored when full unless popping same cycle
//   i_pop / o_dout  : read; o_dout is the head entry (show-ahead)
//   o_full, o_empty, o_count : occupancy
// Push and pop in the same cycle while full is accepted: the head slot
// being read is the one overwritten.
module sdram_arb_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sdram_slot_arb.sv
// sdram_slot_arb: shares the byte-wide SDRAM port between the core
// (zero-latency pass-through), a buffered loader stream and an optional
// aux master. Background traffic uses only slots the core leaves idle.
//   clk_sys, reset : 32 MHz clock, async active-high reset
//   bus (slave)    : mem_sync slot pulse, core/loader/aux request ports,
//                    sdram_* controller port, ldr_full/ldr_overflow,
//                    aux_ack/aux_rdata/aux_rvalid, owner (debug)
// Macro SDRAM_ARB_AUX_EN enables the aux port; when undefined the aux
// inputs are ignored, aux outputs are 0 and the loader always wins.
module sdram_slot_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LDR_DEPTH = 4
) (
  input logic             clk_sys,
  input logic             reset,
  sdram_slot_arb_if.slave bus
);
  localparam int CW = $clog2(LDR_DEPTH) + 1;
  localparam int FW = ADDR_W + 8;

  bg_t           r_bg;
  logic          r_ovf;
  logic [FW-1:0] w_fifo_dout;
  logic          w_fifo_full, w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic          w_consume, w_reload, w_ldr_win, w_drop;

  sdram_arb_fifo #(.WIDTH(FW), .DEPTH(LDR_DEPTH)) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .i_push  (bus.ldr_we),
    .i_din   ({bus.ldr_addr, bus.ldr_data}),
    .i_pop   (w_ldr_win),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // bg is issued at a sync only when the core leaves the slot; it is
  // refilled whenever it ends that sync empty.
  assign w_consume = bus.mem_sync & ~bus.core_req & r_bg.valid;
  assign w_reload  = bus.mem_sync & (~r_bg.valid | w_consume);
  // A strobe into a full FIFO survives only if the head pops this cycle.
  assign w_drop    = bus.ldr_we & (w_fifo_count == CW'(LDR_DEPTH)) & ~w_ldr_win;

  assign bus.ldr_full     = w_fifo_full;
  assign bus.ldr_overflow = r_ovf;

  always_comb begin
    bus.sdram_adr = '0;
    bus.sdram_we  = 1'b0;
    bus.sdram_di  = '0;
    bus.owner     = OWN_IDLE;
    if (bus.core_req) begin
      bus.sdram_adr = bus.core_addr;
      bus.sdram_we  = bus.core_we;
      bus.sdram_di  = bus.core_din;
      bus.owner     = OWN_CORE;
    end else if (r_bg.valid) begin
      bus.sdram_adr = r_bg.addr[ADDR_W-1:0];
      bus.sdram_we  = r_bg.we;
      bus.sdram_di  = r_bg.data;
      bus.owner     = (r_bg.src == SRC_AUX) ? OWN_AUX : OWN_LDR;
    end
  end

`ifdef SDRAM_ARB_AUX_EN
  src_e       r_last;
  logic       r_tag;
  logic       r_rvalid;
  logic [7:0] r_rdata;
  logic       w_aux_win;

  // Round-robin: on a tie the source that did not win last time goes.
  assign w_ldr_win = w_reload & ~w_fifo_empty & (~bus.aux_req | (r_last == SRC_AUX));
  assign w_aux_win = w_reload & bus.aux_req & ~w_ldr_win;

  assign bus.aux_ack    = w_aux_win & ~reset;
  assign bus.aux_rvalid = r_rvalid;
  assign bus.aux_rdata  = r_rdata;

  // A consumed aux read returns its byte one slot later; r_tag marks
  // that the next sync carries the data.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_last   <= SRC_AUX;
      r_tag    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= bus.mem_sync & r_tag;
      if (bus.mem_sync) begin
        r_tag <= w_consume & (r_bg.src == SRC_AUX) & ~r_bg.we;
        if (r_tag) r_rdata <= bus.sdram_do;
      end
      if (w_ldr_win)      r_last <= SRC_LDR;
      else if (w_aux_win) r_last <= SRC_AUX;
    end
  end
`else
  assign w_ldr_win      = w_reload & ~w_fifo_empty;
  assign bus.aux_ack    = 1'b0;
  assign bus.aux_rvalid = 1'b0;
  assign bus.aux_rdata  = '0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_bg  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (w_ldr_win)
        r_bg <= '{valid: 1'b1, src: SRC_LDR, we: 1'b1,
                  addr: ADDR_W_DEF'(w_fifo_dout[FW-1:8]), data: w_fifo_dout[7:0]};
`ifdef SDRAM_ARB_AUX_EN
      else if (w_aux_win)
        r_bg <= '{valid: 1'b1, src: SRC_AUX, we: bus.aux_we,
                  addr: ADDR_W_DEF'(bus.aux_addr), data: bus.aux_din};
`endif
      else if (w_reload)
        r_bg <= '0;
    end
  end
endmodule

// File: tb/tb_sdram_slot_arb.sv
// Bench for sdram_slot_arb: directed scenarios followed by random traffic,
// every cycle compared against a queue-based slot model.
module tb_sdram_slot_arb;
  import sdram_arb_pkg::*;

`ifdef SDRAM_ARB_AUX_EN
  localparam bit AUX_EN = 1'b1;
`else
  localparam bit AUX_EN = 1'b0;
`endif
  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_slot_arb_if #(.ADDR_W(AW)) bus();
  sdram_slot_arb #(.ADDR_W(AW), .LDR_DEPTH(DEPTH)) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  typedef struct {
    bit            valid;
    bit            aux;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } req_t;

  // reference model state
  req_t       ldr_q[$];
  req_t       m_bg;
  bit         m_prefer_ldr;
  bit         m_ovf;
  bit         m_rvalid;
  logic [7:0] m_rdata;
  bit         m_ack;
  int         rd_due[$];
  int         sync_n = 0;

  // DUT-side logs
  owner_e        sync_own[$];
  logic [AW-1:0] sync_adr[$];
  logic [7:0]    sync_di[$];
  logic          sync_we[$];
  int            rvalid_cnt = 0, ack_cnt = 0;
  logic [7:0]    last_rdata = '0;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    ldr_q.delete();
    rd_due.delete();
    m_bg = '{valid: 0, aux: 0, we: 0, addr: '0, data: '0};
    m_prefer_ldr = 1'b1;
    m_ovf = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = '0;
    m_ack = 1'b0;
  endfunction

  // 0 none, 1 loader, 2 aux
  function automatic int winner();
    bit l = (ldr_q.size() != 0);
    bit a = AUX_EN && bus.aux_req;
    if (l && (!a || m_prefer_ldr)) return 1;
    if (a) return 2;
    return 0;
  endfunction

  function automatic bit refill_now();
    return bus.mem_sync && (!m_bg.valid || !bus.core_req);
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] ea;
    logic          ewe;
    logic [7:0]    edi;
    owner_e        eo;
    bit            eack;
    ea = '0; ewe = 1'b0; edi = '0; eo = OWN_IDLE;
    if (bus.core_req) begin
      ea = bus.core_addr; ewe = bus.core_we; edi = bus.core_din; eo = OWN_CORE;
    end else if (m_bg.valid) begin
      ea = m_bg.addr; ewe = m_bg.we; edi = m_bg.data; eo = m_bg.aux ? OWN_AUX : OWN_LDR;
    end
    eack = !rst && refill_now() && (winner() == 2);
    chk("sdram_adr", 32'(bus.sdram_adr), 32'(ea));
    chk("sdram_we", 32'(bus.sdram_we), 32'(ewe));
    chk("sdram_di", 32'(bus.sdram_di), 32'(edi));
    chk("owner", 32'(bus.owner), 32'(eo));
    chk("ldr_full", 32'(bus.ldr_full), 32'(ldr_q.size() == DEPTH));
    chk("ldr_overflow", 32'(bus.ldr_overflow), 32'(m_ovf));
    chk("aux_ack", 32'(bus.aux_ack), 32'(eack));
    chk("aux_rvalid", 32'(bus.aux_rvalid), 32'(m_rvalid));
    chk("aux_rdata", 32'(bus.aux_rdata), 32'(m_rdata));
    if (bus.mem_sync) begin
      sync_own.push_back(bus.owner);
      sync_adr.push_back(bus.sdram_adr);
      sync_di.push_back(bus.sdram_di);
      sync_we.push_back(bus.sdram_we);
    end
    if (bus.aux_rvalid) begin rvalid_cnt++; last_rdata = bus.aux_rdata; end
    if (bus.aux_ack) ack_cnt++;
  endtask

  task automatic model_update();
    bit consumed;
    int w;
    if (rst) begin model_reset(); return; end
    m_ack = 1'b0;
    m_rvalid = 1'b0;
    if (bus.mem_sync) begin
      sync_n++;
      if (rd_due.size() != 0 && rd_due[0] == sync_n) begin
        m_rdata = bus.sdram_do;
        m_rvalid = 1'b1;
        void'(rd_due.pop_front());
      end
      consumed = m_bg.valid && !bus.core_req;
      if (consumed && m_bg.aux && !m_bg.we) rd_due.push_back(sync_n + 1);
      if (!m_bg.valid || consumed) begin
        w = winner();
        if (w == 1) begin
          m_bg = ldr_q.pop_front();
          m_prefer_ldr = 1'b0;
        end else if (w == 2) begin
          m_bg = '{valid: 1, aux: 1, we: bus.aux_we, addr: bus.aux_addr, data: bus.aux_din};
          m_prefer_ldr = 1'b1;
          m_ack = 1'b1;
        end else begin
          m_bg.valid = 1'b0;
        end
      end
    end
    if (bus.ldr_we) begin
      if (ldr_q.size() < DEPTH)
        ldr_q.push_back('{valid: 1, aux: 0, we: 1, addr: bus.ldr_addr, data: bus.ldr_data});
      else
        m_ovf = 1'b1;
    end
  endtask

  task automatic tick(input bit s);
    bus.mem_sync = s;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    bus.mem_sync = 1'b0;
    bus.ldr_we = 1'b0;
    if (m_ack) bus.aux_req = 1'b0;
  endtask

  task automatic slot();
    tick(1'b1);
    repeat (3) tick(1'b0);
  endtask

  task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
    bus.ldr_we = 1'b1; bus.ldr_addr = a; bus.ldr_data = d;
    tick(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    sync_own.delete(); sync_adr.delete(); sync_di.delete(); sync_we.delete();
  endtask

  initial begin
    int rv0, ack0, len;
    bus.mem_sync = 0; bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_din = '0;
    bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_data = '0;
    bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_din = '0; bus.sdram_do = '0;
    model_reset();
    repeat (3) tick(1'b0);
    chk("rst_owner", 32'(bus.owner), 32'(OWN_IDLE));
    chk("rst_ovf", 32'(bus.ldr_overflow), 32'd0);
    chk("rst_full", 32'(bus.ldr_full), 32'd0);
    rst = 1'b0;
    tick(1'b0);

    // loader burst, idle core: one write per slot, in order
    for (int i = 0; i < 4; i++) strobe(25'h0280000 + AW'(i), 8'h11 + 8'(i));
    clear_logs();
    repeat (5) slot();
    chk("t1_syncs", 32'(sync_own.size()), 32'd5);
    if (sync_own.size() >= 5)
      for (int i = 0; i < 4; i++) begin
        chk("t1_own", 32'(sync_own[i+1]), 32'(OWN_LDR));
        chk("t1_adr", 32'(sync_adr[i+1]), 32'h0280000 + 32'(i));
        chk("t1_di", 32'(sync_di[i+1]), 32'h11 + 32'(i));
        chk("t1_we", 32'(sync_we[i+1]), 32'd1);
      end
    chk("t1_ovf", 32'(bus.ldr_overflow), 32'd0);

    // overflow: six strobes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) strobe(25'h0280100 + AW'(i), 8'h21 + 8'(i));
    chk("t2_full", 32'(bus.ldr_full), 32'd1);
    chk("t2_ovf", 32'(bus.ldr_overflow), 32'd1);
    clear_logs();
    repeat (6) slot();
    if (sync_own.size() >= 5)
      for (int i = 0; i < 4; i++)
        chk("t2_adr", 32'(sync_adr[i+1]), 32'h0280100 + 32'(i));
    chk("t2_ovf_sticky", 32'(bus.ldr_overflow), 32'd1);
    do_reset();
    chk("t2_ovf_clr", 32'(bus.ldr_overflow), 32'd0);

    // core holds three slots while loader is pending
    strobe(25'h0280010, 8'h31);
    strobe(25'h0280011, 8'h32);
    clear_logs();
    bus.core_req = 1'b1;
    repeat (3) begin
      bus.core_addr = AW'($urandom); bus.core_we = 1'($urandom); bus.core_din = 8'($urandom);
      slot();
    end
    bus.core_req = 1'b0;
    repeat (3) slot();
    chk("t3_syncs", 32'(sync_own.size()), 32'd6);
    if (sync_own.size() >= 5) begin
      for (int i = 0; i < 3; i++) chk("t3_core", 32'(sync_own[i]), 32'(OWN_CORE));
      chk("t3_first_own", 32'(sync_own[3]), 32'(OWN_LDR));
      chk("t3_first_adr", 32'(sync_adr[3]), 32'h0280010);
      chk("t3_second_adr", 32'(sync_adr[4]), 32'h0280011);
    end

`ifdef SDRAM_ARB_AUX_EN
    // loader then aux read, data one slot later
    do_reset();
    bus.sdram_do = 8'hA5;
    strobe(25'h0280020, 8'h41);
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 25'h0000100; bus.aux_din = 8'h00;
    clear_logs();
    rv0 = rvalid_cnt;
    repeat (5) slot();
    if (sync_own.size() >= 3) begin
      chk("t4_ldr_own", 32'(sync_own[1]), 32'(OWN_LDR));
      chk("t4_aux_own", 32'(sync_own[2]), 32'(OWN_AUX));
      chk("t4_aux_adr", 32'(sync_adr[2]), 32'h0000100);
      chk("t4_aux_we", 32'(sync_we[2]), 32'd0);
    end
    chk("t4_rvalid_cnt", 32'(rvalid_cnt - rv0), 32'd1);
    chk("t4_rdata", 32'(last_rdata), 32'hA5);

    // reset while a read tag is in flight
    do_reset();
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 25'h0000200;
    slot();
    slot();
    do_reset();
    rv0 = rvalid_cnt;
    repeat (3) slot();
    chk("t5_no_rvalid", 32'(rvalid_cnt - rv0), 32'd0);
    chk("t5_owner", 32'(bus.owner), 32'(OWN_IDLE));
    chk("t5_adr", 32'(bus.sdram_adr), 32'd0);
`else
    // aux held without the aux port: never acked, loader unaffected
    do_reset();
    bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 25'h0000300; bus.aux_din = 8'h77;
    for (int i = 0; i < 4; i++) strobe(25'h0280040 + AW'(i), 8'h51 + 8'(i));
    clear_logs();
    ack0 = ack_cnt;
    repeat (5) slot();
    if (sync_own.size() >= 5)
      for (int i = 0; i < 4; i++) begin
        chk("t6_own", 32'(sync_own[i+1]), 32'(OWN_LDR));
        chk("t6_adr", 32'(sync_adr[i+1]), 32'h0280040 + 32'(i));
      end
    chk("t6_no_ack", 32'(ack_cnt - ack0), 32'd0);
    bus.aux_req = 1'b0;
`endif

    // random traffic against the model
    do_reset();
    for (int s = 0; s < 200; s++) begin
      if (s == 100) do_reset();
      bus.core_req  = ($urandom_range(0, 2) == 0);
      bus.core_we   = 1'($urandom);
      bus.core_addr = AW'($urandom);
      bus.core_din  = 8'($urandom);
      len = $urandom_range(4, 6);
      for (int c = 0; c < len; c++) begin
        if (!bus.aux_req && $urandom_range(0, 3) == 0) begin
          bus.aux_req = 1'b1; bus.aux_we = 1'($urandom);
          bus.aux_addr = AW'($urandom); bus.aux_din = 8'($urandom);
        end
        if ($urandom_range(0, 2) == 0) begin
          bus.ldr_we = 1'b1; bus.ldr_addr = AW'($urandom); bus.ldr_data = 8'($urandom);
        end
        bus.sdram_do = 8'($urandom);
        tick(c == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
